// File: rtl/virtual_src_pkg.sv
// Shared types and constants for the virtual traffic source.
// Flit layout: [DW-1:DW-2] flit type, [DW-3:0] payload.
// Sizes are taken from params.svh so every block agrees on them.
`include "params.svh"

package virtual_src_pkg;

    localparam int DW        = `DW;
    localparam int PAY_W     = `DW - 2;
    localparam int PKT_LEN   = `PKT_LEN;
    localparam int BUF_ALLOC = `BUFFER_ALLOC;
    localparam int CNT_W     = `BUFFER_ALLOC_LOG + 1;

    localparam logic [1:0] FLIT_HEAD = `HEAD;
    localparam logic [1:0] FLIT_BODY = `BODY;
    localparam logic [1:0] FLIT_TAIL = `TAIL;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_TAIL,
        ST_GAP,
        ST_DONE
    } state_e;

    // Pack a flit type and payload into one bus word.
    function automatic logic [DW-1:0] make_flit(input logic [1:0]       ftype,
                                                input logic [PAY_W-1:0] payload);
        return {ftype, payload};
    endfunction

endpackage

// File: rtl/params.svh
// Shared flit format and downstream buffer sizing for the virtual source.
`ifndef VIRTUAL_SRC_PARAMS_SVH
`define VIRTUAL_SRC_PARAMS_SVH

`define DW               32
`define PKT_LEN          4
`define BUFFER_ALLOC     8
`define BUFFER_ALLOC_LOG 3

`define HEAD 2'b01
`define BODY 2'b10
`define TAIL 2'b11

`endif

// File: rtl/virtual_src_credit_counter.sv
// Purpose: up/down credit counter, saturating at MAX, with sticky overflow flag.
// Latency: count and flag update one cycle after dec_i/inc_i.
// Backpressure: none; inc_i at MAX without dec_i saturates and raises err_o.
module virtual_src_credit_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         dec_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         err_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;

    // Net change per cycle: a simultaneous return and spend cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == MAX_V) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE_V;
            end
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE_V;
        end
    end

    // Credits start full; the overflow flag only clears on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= MAX_V;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_o = cnt_q;
    assign err_o = err_q;

endmodule

// File: rtl/virtual_src.sv
// Purpose: credit-based packet generator emitting PKT_NUM HEAD/BODY/TAIL packets per start pulse.
// Latency: start in cycle N -> first HEAD valid in cycle N+1; one flit per cycle when unstalled.
// Backpressure: holds valid_o/data_o until ready_i; stalls with valid_o low when no credits remain.
module virtual_src
    import virtual_src_pkg::*;
#(
    parameter logic [9:0] stream_id = 10'd0,
    parameter int         PKT_NUM   = 4,
    parameter int         GAP       = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    input  logic             ready_i,
    input  logic             credit_upd,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             done,
    output logic             credit_err
);

    localparam logic [9:0]  LAST_PKT  = 10'(PKT_NUM - 1);
    localparam logic [7:0]  LAST_GAP  = 8'(GAP - 1);
    localparam logic [15:0] LAST_BODY = 16'(PKT_LEN - 3);

    state_e           state_q, state_d;
    logic [9:0]       pkt_q, pkt_d;      // packet index within the burst
    logic [15:0]      bidx_q, bidx_d;    // body flit index within the packet
    logic [PAY_W-1:0] bctr_q, bctr_d;    // running body payload across the burst
    logic [7:0]       gap_q, gap_d;      // idle cycles spent in GAP

    logic xfer;
    logic credit_ok;

    assign credit_ok = (credit_cnt != '0);
    assign xfer      = valid_o & ready_i;

    virtual_src_credit_counter #(
        .W   (CNT_W),
        .MAX (BUF_ALLOC)
    ) u_credit_counter (
        .clk   (clk),
        .rstn  (rstn),
        .dec_i (xfer),
        .inc_i (credit_upd),
        .cnt_o (credit_cnt),
        .err_o (credit_err)
    );

    // FSM state register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance only on accepted flits, or on the gap timer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_HEAD;
            end
            ST_HEAD: begin
                if (xfer) state_d = (PKT_LEN > 2) ? ST_BODY : ST_TAIL;
            end
            ST_BODY: begin
                if (xfer && (bidx_q == LAST_BODY)) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                if (xfer) begin
                    if (pkt_q == LAST_PKT) begin
                        state_d = ST_DONE;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_HEAD;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == LAST_GAP) state_d = ST_HEAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter next-state: a start only lands in IDLE/DONE, so mid-burst pulses touch nothing.
    always_comb begin
        pkt_d  = pkt_q;
        bidx_d = bidx_q;
        bctr_d = bctr_q;
        gap_d  = gap_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pkt_d  = '0;
                    bidx_d = '0;
                    bctr_d = '0;
                    gap_d  = '0;
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    bctr_d = bctr_q + PAY_W'(1);
                    bidx_d = (bidx_q == LAST_BODY) ? 16'd0 : bidx_q + 16'd1;
                end
            end
            ST_TAIL: begin
                if (xfer && (pkt_q != LAST_PKT)) begin
                    pkt_d = pkt_q + 10'd1;
                    gap_d = '0;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 8'd1;
            end
            default: begin
            end
        endcase
    end

    // Packet bookkeeping registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_q  <= '0;
            bidx_q <= '0;
            bctr_q <= '0;
            gap_q  <= '0;
        end else begin
            pkt_q  <= pkt_d;
            bidx_q <= bidx_d;
            bctr_q <= bctr_d;
            gap_q  <= gap_d;
        end
    end

    // Outputs decode registers only, so valid_o has no path from ready_i.
    always_comb begin
        valid_o = 1'b0;
        data_o  = '0;
        done    = 1'b0;
        unique case (state_q)
            ST_HEAD: begin
                valid_o = credit_ok;
                data_o  = make_flit(FLIT_HEAD, PAY_W'(stream_id));
            end
            ST_BODY: begin
                valid_o = credit_ok;
                data_o  = make_flit(FLIT_BODY, bctr_q);
            end
            ST_TAIL: begin
                valid_o = credit_ok;
                data_o  = make_flit(FLIT_TAIL, PAY_W'(pkt_q));
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_virtual_src.sv
`timescale 1ns/1ps
module tb_virtual_src;
    import virtual_src_pkg::*;

    localparam logic [9:0] SID_A = 10'h2A5;
    localparam logic [9:0] SID_B = 10'h011;
    localparam int         PKTS  = 2;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    // instance A: GAP=0, instance B: GAP=3
    logic             start_a, ready_a, cupd_a, valid_a, done_a, err_a;
    logic [DW-1:0]    data_a;
    logic [CNT_W-1:0] cnt_a;
    logic             start_b, ready_b, cupd_b, valid_b, done_b, err_b;
    logic [DW-1:0]    data_b;
    logic [CNT_W-1:0] cnt_b;

    virtual_src #(.stream_id(SID_A), .PKT_NUM(PKTS), .GAP(0)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .valid_o(valid_a), .data_o(data_a),
        .ready_i(ready_a), .credit_upd(cupd_a), .credit_cnt(cnt_a), .done(done_a),
        .credit_err(err_a));

    virtual_src #(.stream_id(SID_B), .PKT_NUM(PKTS), .GAP(3)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .valid_o(valid_b), .data_o(data_b),
        .ready_i(ready_b), .credit_upd(cupd_b), .credit_cnt(cnt_b), .done(done_b),
        .credit_err(err_b));

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards of expected flits
    logic [DW-1:0] exp_a[$];
    logic [DW-1:0] exp_b[$];

    task automatic push_exp(input bit to_b, input logic [9:0] sid, input int npkt);
        logic [PAY_W-1:0] bc;
        logic [DW-1:0]    f;
        bc = '0;
        for (int p = 0; p < npkt; p++) begin
            f = {FLIT_HEAD, PAY_W'(sid)};
            if (to_b) exp_b.push_back(f); else exp_a.push_back(f);
            for (int b = 0; b < PKT_LEN - 2; b++) begin
                f = {FLIT_BODY, bc};
                if (to_b) exp_b.push_back(f); else exp_a.push_back(f);
                bc = bc + PAY_W'(1);
            end
            f = {FLIT_TAIL, PAY_W'(p)};
            if (to_b) exp_b.push_back(f); else exp_a.push_back(f);
        end
    endtask

    // Downstream model for A: FIFO occupancy and credit return modes
    int   fifo_mode = 0;   // 0 manual credits, 1 pop every cycle, 2 random pop
    logic cupd_man, cupd_loop;
    logic rdy_man, rdy_rnd, rdy_rand_en;
    int   occ = 0;
    int   max_occ = 0;
    int   xfer_a_cnt = 0;
    int   cyc = 0;

    assign cupd_a  = (fifo_mode == 0) ? cupd_man : cupd_loop;
    assign ready_a = rdy_rand_en ? rdy_rnd : rdy_man;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (fifo_mode == 1)      cupd_loop = (occ > 0);
        else if (fifo_mode == 2) cupd_loop = (occ > 0) && ($urandom_range(0, 3) != 0);
        else                     cupd_loop = 1'b0;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    // Monitor A: scoreboard, hold-while-stalled, FIFO occupancy
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_dat;
    always @(negedge clk) begin
        if (!rstn) begin
            occ = 0;
            max_occ = 0;
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_vld_a", valid_a, 1'b1);
                check_eq("hold_dat_a", data_a, hold_dat);
            end
            if (valid_a && ready_a) begin
                xfer_a_cnt++;
                if (exp_a.size() == 0) check_eq("sb_a_underrun", exp_a.size(), 1);
                else                   check_eq("flit_a", data_a, exp_a.pop_front());
            end
            hold_pend = valid_a && !ready_a;
            hold_dat  = data_a;
            occ = occ + ((valid_a && ready_a) ? 1 : 0) - (cupd_a ? 1 : 0);
            if (occ < 0) occ = 0;
            if (occ > max_occ) max_occ = occ;
        end
    end

    // Monitor B: scoreboard and gap measurement
    int xfer_b_cnt = 0;
    int tail_b_cnt = 0;
    int last_tail_cyc = 0;
    int gap_meas = -1;
    bit tail_seen = 1'b0;
    always @(negedge clk) begin
        if (rstn && valid_b && ready_b) begin
            xfer_b_cnt++;
            if (data_b[DW-1:DW-2] == FLIT_HEAD && tail_seen) gap_meas = cyc - last_tail_cyc;
            if (data_b[DW-1:DW-2] == FLIT_TAIL) begin
                tail_b_cnt++;
                last_tail_cyc = cyc;
                tail_seen = 1'b1;
            end
            if (exp_b.size() == 0) check_eq("sb_b_underrun", exp_b.size(), 1);
            else                   check_eq("flit_b", data_b, exp_b.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        rdy_man = 1'b1; ready_b = 1'b1;
        cupd_man = 1'b0; cupd_b = 1'b0;
        fifo_mode = 0; rdy_rand_en = 1'b0;
        exp_a.delete(); exp_b.delete();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic wait_done_a(input string tag);
        int n;
        n = 0;
        while (!done_a && n < 2000) begin
            tick();
            n++;
        end
        check_eq(tag, done_a, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        logic [DW-1:0] b0;

        // ---- reset values ----
        #1;
        rstn = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        rdy_man = 1'b1; ready_b = 1'b1;
        cupd_man = 1'b0; cupd_b = 1'b0;
        fifo_mode = 0; rdy_rand_en = 1'b0;
        repeat (2) tick();
        check_eq("rst_valid", valid_a, 1'b0);
        check_eq("rst_data", data_a, '0);
        check_eq("rst_done", done_a, 1'b0);
        check_eq("rst_err", err_a, 1'b0);
        check_eq("rst_cnt", cnt_a, 8);
        rstn = 1'b1;
        tick();

        // ---- contiguous burst with FIFO popping every cycle ----
        fifo_mode = 1;
        start_a = 1'b1;
        push_exp(1'b0, SID_A, PKTS);
        tick();
        start_a = 1'b0;
        @(negedge clk);
        check_eq("start_latency", valid_a, 1'b1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check_eq("contig", valid_a && ready_a, 1'b1);
        end
        @(negedge clk);
        check_eq("done_after_tail", done_a, 1'b1);
        check_eq("idle_after_done", valid_a, 1'b0);
        check_eq("sb_a_drained", exp_a.size(), 0);
        tick(); tick(); tick();
        check_eq("cnt_restored", cnt_a, 8);
        check_eq("no_err_loop", err_a, 1'b0);

        // ---- no credit return; mid-burst start ignored ----
        do_reset();
        base = xfer_a_cnt;
        start_a = 1'b1;
        push_exp(1'b0, SID_A, PKTS);
        tick();
        start_a = 1'b0;
        tick(); tick();
        start_a = 1'b1;            // lands in BODY: must be ignored
        tick();
        start_a = 1'b0;
        repeat (8) tick();
        check_eq("xfers_8", xfer_a_cnt - base, 8);
        check_eq("stall_cnt", cnt_a, 0);
        check_eq("stall_done", done_a, 1'b1);
        start_a = 1'b1;
        push_exp(1'b0, SID_A, PKTS);
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        check_eq("nocred_vld", valid_a, 1'b0);
        base = xfer_a_cnt;
        cupd_man = 1'b1;
        tick();
        cupd_man = 1'b0;
        repeat (5) tick();
        check_eq("one_more_flit", xfer_a_cnt - base, 1);
        check_eq("nocred_vld2", valid_a, 1'b0);
        check_eq("nocred_cnt2", cnt_a, 0);

        // ---- overflow at full credits, ready stall, coincident credit ----
        do_reset();
        cupd_man = 1'b1;
        tick();
        cupd_man = 1'b0;
        check_eq("ovf_cnt", cnt_a, 8);
        check_eq("ovf_err", err_a, 1'b1);
        base = xfer_a_cnt;
        start_a = 1'b1;
        push_exp(1'b0, SID_A, PKTS);
        tick();
        start_a = 1'b0;              // HEAD valid, transfers this cycle
        tick();
        rdy_man = 1'b0;              // first BODY valid, stalled 3 cycles
        b0 = {FLIT_BODY, PAY_W'(0)};
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_vld", valid_a, 1'b1);
            check_eq("stall_dat", data_a, b0);
            check_eq("stall_cnt7", cnt_a, 7);
            tick();
        end
        check_eq("stall_vld4", valid_a, 1'b1);
        rdy_man = 1'b1;
        cupd_man = 1'b1;
        tick();
        cupd_man = 1'b0;
        check_eq("coinc_cnt", cnt_a, 7);
        check_eq("xfer_on_4th", xfer_a_cnt - base, 2);
        check_eq("err_sticky", err_a, 1'b1);
        wait_done_a("burst_done_stall");

        // ---- GAP=3 spacing and reset mid-packet (instance B) ----
        do_reset();
        start_b = 1'b1;
        push_exp(1'b1, SID_B, PKTS);
        tick();
        start_b = 1'b0;
        n = 0;
        while (xfer_b_cnt < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("b_reach_head2", xfer_b_cnt, 5);
        check_eq("gap_cycles", gap_meas - 1, 3);
        check_eq("b_body_vld", valid_b, 1'b1);
        rstn = 1'b0;
        #1;
        check_eq("arst_valid", valid_b, 1'b0);
        check_eq("arst_data", data_b, '0);
        check_eq("arst_cnt", cnt_b, 8);
        check_eq("arst_done", done_b, 1'b0);
        check_eq("arst_err", err_b, 1'b0);
        tick(); tick();
        rstn = 1'b1;
        repeat (10) tick();
        check_eq("no_tail_after_rst", tail_b_cnt, 1);
        check_eq("abandoned_flits", exp_b.size(), 3);
        check_eq("idle_after_rst", valid_b, 1'b0);

        // ---- 100 packets, random ready and credit return ----
        do_reset();
        base = xfer_a_cnt;
        fifo_mode = 2;
        rdy_rand_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            start_a = 1'b1;
            push_exp(1'b0, SID_A, PKTS);
            tick();
            start_a = 1'b0;
            wait_done_a("burst_done_rand");
        end
        fifo_mode = 1;
        repeat (20) tick();
        check_eq("rand_xfers", xfer_a_cnt - base, 400);
        check_eq("fifo_no_ovf", (max_occ > 8), 1'b0);
        check_eq("rand_no_err", err_a, 1'b0);
        check_eq("rand_sb_drained", exp_a.size(), 0);
        check_eq("rand_cnt_full", cnt_a, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
